counter4bit_checker: RTL
========================

Name: counter4bit_checker

Overview:
Receive-side sequence checker for the 4-bit up-counter output bus. It samples the count stream, locks once the stream increments by one per qualified sample, and then reports sequence errors and wrap-arounds. It sits downstream of the counter in simulation and on-chip self-test, and consumes the same clk/Reset domain.

Parameters:
WIDTH, 4, width of the observed count bus
LOCK_CNT, 2, consecutive correct increments required to enter LOCKED (>=1)
ERR_W, 8, width of Error_count and Wrap_count

Ports:
clk  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-high reset
Enable  input  1  sample qualifier; Count_in is sampled only on edges with Enable=1
Count_in  input  WIDTH  observed counter value
Locked  output  1  high while the checker is in LOCKED
Error  output  1  one-cycle pulse on an in-lock sequence mismatch
Error_count  output  ERR_W  saturating count of Error pulses
Wrap  output  1  one-cycle pulse on an observed max->0 correct transition
Wrap_count  output  ERR_W  count of Wrap pulses, wraps modulo 2^ERR_W

Behaviour:
- All state is in one clock domain. Reset is asynchronous and active-high.
- While Reset=1: state=IDLE, prev=0, good_run=0, Locked=0, Error=0, Error_count=0, Wrap=0, Wrap_count=0. These take effect immediately, without waiting for a clock edge.
- All outputs are registered. Latency is 1 cycle: a response reflects the sample taken on the preceding edge.
- Define match = (Count_in == (prev + 1) mod 2^WIDTH). The addition is WIDTH bits wide and carry is discarded.
- Error and Wrap are cleared on every edge unless re-asserted on that edge. They never stay high for two consecutive cycles from a single event.
- Enable=0: state, prev, good_run and both counters hold. Error=0 and Wrap=0.
- State machine, evaluated only on edges with Enable=1:
  - IDLE: prev <= Count_in; good_run <= 0; go to SYNC. No match is evaluated.
  - SYNC, match: good_run <= good_run+1. If good_run+1 == LOCK_CNT, go to LOCKED and Locked=1 from the next cycle. Otherwise stay in SYNC.
  - SYNC, mismatch: good_run <= 0; stay in SYNC. No Error (not locked).
  - LOCKED, match: stay in LOCKED.
  - LOCKED, mismatch: Error=1 for one cycle; Error_count increments and saturates at 2^ERR_W-1; Locked=0; go to SYNC; good_run <= 0.
- In SYNC and LOCKED, prev <= Count_in on every enabled edge, including mismatches. This resynchronises to the new value.
- A repeated value (Count_in == prev) is a mismatch. Any jump other than +1 mod 2^WIDTH is a mismatch.
- Wrap: in SYNC or LOCKED, if match and prev == 2^WIDTH-1 (so Count_in == 0), then Wrap=1 and Wrap_count increments modulo 2^ERR_W.
  - A wrap can occur on the same edge as a SYNC->LOCKED transition; both take effect.
  - A mismatch that lands on 0 is not a wrap.
- Simultaneous events:
  - Error and Wrap are mutually exclusive by construction.
  - A lock transition and Wrap on the same edge are both reported.
- Reset mid-operation: all state is cleared immediately. After release, the first enabled sample takes the IDLE path.
- No X-propagation: Count_in is treated as valid whenever Enable=1.

Test Plan:
1. Reset 2 cycles, release. Enable=1, feed 0,1,...,15,0,1 one per clock.
   - Locked rises the cycle after sample 2 (LOCK_CNT=2).
   - Wrap pulses exactly once, the cycle after sample 0 following 15; Wrap_count=1.
   - Error_count stays 0 and Error never asserts.
2. Locked on the sequence 4,5,6, then feed 9.
   - Error=1 for one cycle after the 9 sample; Error_count=1; Locked=0.
   - Then feed 10,11: Locked=1 again the cycle after 11.
3. Locked at 7, feed 7 again (stalled counter).
   - Error pulse; Error_count increments by 1; Locked=0.
4. ERR_W=2 override. Lock, then inject 5 separate mismatches, relocking between each.
   - Error_count reads 1,2,3,3,3 (saturates at 3).
   - Error pulses 5 times.
5. Locked at 3. Drop Enable for 3 cycles while Count_in=12,0,9, then Enable=1 with Count_in=4.
   - No Error, no Wrap, and Locked stays 1 throughout.
   - Counters are unchanged.
6. Mid-stream while locked with Wrap_count=2, assert Reset between clock edges.
   - All outputs read 0 before the next edge.
   - After release, feed 8,9,10: Locked=1 the cycle after 10, with no Error.

Source files
------------

// File: rtl/counter4bit_checker_if.sv
// Observed count stream plus the checker's status outputs.
// The count source drives through master; the checker binds slave.
interface counter4bit_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             Enable;
  logic [WIDTH-1:0] Count_in;
  logic             Locked;
  logic             Error;
  logic [ERR_W-1:0] Error_count;
  logic             Wrap;
  logic [ERR_W-1:0] Wrap_count;

  modport master (
    output Enable, Count_in,
    input  Locked, Error, Error_count, Wrap, Wrap_count
  );

  modport slave (
    input  Enable, Count_in,
    output Locked, Error, Error_count, Wrap, Wrap_count
  );
endinterface

// File: rtl/counter4bit_checker.sv
// Sequence checker for an up-counter bus: locks after LOCK_CNT consecutive +1 steps,
// then flags sequence errors (saturating count) and max->0 wraps (modulo count).
module counter4bit_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic                   clk,
  input  logic                   Reset,
  counter4bit_checker_if.slave   bus
);
  localparam int GR_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [GR_W-1:0] LOCK_V = GR_W'(LOCK_CNT);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_LOCKED} state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_prev, w_prev_nx;
  logic [GR_W-1:0]  r_good_run, w_gr_nx;
  logic             r_locked;
  logic             r_err, w_err_nx;
  logic             r_wrap, w_wrap_nx;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nx;
  logic [ERR_W-1:0] r_wrap_cnt, w_wrap_cnt_nx;

  logic [WIDTH-1:0] w_prev_inc;
  logic [GR_W-1:0]  w_gr_inc;
  logic             w_match;
  logic             w_at_max;

  // Increment is WIDTH bits wide so 15+1 compares equal to 0
  assign w_prev_inc = r_prev + WIDTH'(1);
  assign w_match    = (bus.Count_in == w_prev_inc);
  assign w_at_max   = &r_prev;
  assign w_gr_inc   = r_good_run + GR_W'(1);

  always_comb begin
    w_state_nx    = r_state;
    w_prev_nx     = r_prev;
    w_gr_nx       = r_good_run;
    w_err_nx      = 1'b0;
    w_wrap_nx     = 1'b0;
    w_err_cnt_nx  = r_err_cnt;
    w_wrap_cnt_nx = r_wrap_cnt;
    if (bus.Enable) begin
      w_prev_nx = bus.Count_in;
      case (r_state)
        S_IDLE: begin
          w_gr_nx    = '0;
          w_state_nx = S_SYNC;
        end
        S_SYNC: begin
          if (w_match) begin
            w_gr_nx = w_gr_inc;
            if (w_gr_inc == LOCK_V) w_state_nx = S_LOCKED;
            if (w_at_max) begin
              w_wrap_nx     = 1'b1;
              w_wrap_cnt_nx = r_wrap_cnt + ERR_W'(1);
            end
          end else begin
            w_gr_nx = '0;
          end
        end
        S_LOCKED: begin
          if (w_match) begin
            if (w_at_max) begin
              w_wrap_nx     = 1'b1;
              w_wrap_cnt_nx = r_wrap_cnt + ERR_W'(1);
            end
          end else begin
            w_err_nx   = 1'b1;
            w_gr_nx    = '0;
            w_state_nx = S_SYNC;
            if (~&r_err_cnt) w_err_cnt_nx = r_err_cnt + ERR_W'(1);
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_prev     <= '0;
      r_good_run <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_wrap     <= 1'b0;
      r_err_cnt  <= '0;
      r_wrap_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_prev     <= w_prev_nx;
      r_good_run <= w_gr_nx;
      r_locked   <= (w_state_nx == S_LOCKED);
      r_err      <= w_err_nx;
      r_wrap     <= w_wrap_nx;
      r_err_cnt  <= w_err_cnt_nx;
      r_wrap_cnt <= w_wrap_cnt_nx;
    end
  end

  assign bus.Locked      = r_locked;
  assign bus.Error       = r_err;
  assign bus.Error_count = r_err_cnt;
  assign bus.Wrap        = r_wrap;
  assign bus.Wrap_count  = r_wrap_cnt;
endmodule
